// File: rtl/vscpu_pkg.sv
// Shared types and constants for the VerySimpleCPU boot loader.
package vscpu_pkg;

    // Loader FSM states, in frame order.
    typedef enum logic [2:0] {
        S_SYNC    = 3'd0,
        S_ADDR_HI = 3'd1,
        S_ADDR_LO = 3'd2,
        S_CNT_HI  = 3'd3,
        S_CNT_LO  = 3'd4,
        S_DATA    = 3'd5,
        S_WRITE   = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         WORD_BYTES        = 4;
    localparam int         BYTE_IDX_W        = $clog2(WORD_BYTES);

    // The loader accepts host bytes in every state except the write
    // stall cycle and the terminal state.
    function automatic logic loader_ready(input state_t s);
        return !(s == S_WRITE || s == S_DONE);
    endfunction

endpackage

// File: rtl/vscpu_byte_packer.sv
// Assembles four host bytes, MSB first, into one 32-bit word.
// word_valid_o is high in the cycle the fourth byte is being accepted;
// word_o then holds the complete word from the following cycle on and
// stays stable until the next accepted byte.
module vscpu_byte_packer
    import vscpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [31:0]           shift_q;
    logic [BYTE_IDX_W-1:0] idx_q;

    // Shift in accepted bytes and track the byte position within the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= 32'd0;
            idx_q   <= '0;
        end else if (clear_i) begin
            idx_q   <= '0;
        end else if (byte_valid_i) begin
            shift_q <= {shift_q[23:0], byte_i};
            idx_q   <= idx_q + BYTE_IDX_W'(1);
        end
    end

    assign word_o       = shift_q;
    assign word_valid_o = byte_valid_i && !clear_i &&
                          (idx_q == BYTE_IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/vscpu_boot_loader.sv
// Boot loader for VerySimpleCPU: owns the RAM port after reset, loads a
// framed byte stream (sync, start address, word count, big-endian words)
// into consecutive RAM addresses, then hands the port to the CPU and
// releases the CPU reset.
//
// Host handshake: a byte transfers on a rising edge where in_valid and
// in_ready are both high; in_valid may drop at any byte, and a byte
// offered while in_ready is low must be held by the host.
module vscpu_boot_loader
    import vscpu_pkg::*;
#(
    parameter int         SIZE      = 14,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    output logic            in_ready,
    input  logic            cpu_wrEn,
    input  logic [SIZE-1:0] cpu_addr,
    input  logic [31:0]     cpu_data,
    output logic            ram_we,
    output logic [SIZE-1:0] ram_addr,
    output logic [31:0]     ram_data,
    output logic            cpu_rst,
    output logic            done,
    output logic [15:0]     words_written,
    output state_t          dbg_state
);

    state_t          state_q;
    logic [7:0]      addr_hi_q;
    logic [15:0]     cnt_q;
    logic [SIZE-1:0] ptr_q;
    logic [15:0]     words_q;
    logic            wr_q;
    logic            done_q;
    logic            cpu_rst_q;

    logic            accept;
    logic            packer_clear;
    logic            packer_valid;
    logic [31:0]     packed_word;
    logic            word_valid;

    assign in_ready     = loader_ready(state_q);
    assign accept       = in_valid && in_ready;
    // Byte index is held at zero outside DATA so every word starts aligned.
    assign packer_clear = (state_q != S_DATA);
    assign packer_valid = accept && (state_q == S_DATA);

    vscpu_byte_packer u_packer (
        .clk          (clk),
        .rst_n        (rst),
        .clear_i      (packer_clear),
        .byte_valid_i (packer_valid),
        .byte_i       (in_data),
        .word_o       (packed_word),
        .word_valid_o (word_valid)
    );

    // Frame-parsing FSM with registered write strobe and handover outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_SYNC;
            addr_hi_q <= 8'd0;
            cnt_q     <= 16'd0;
            ptr_q     <= '0;
            words_q   <= 16'd0;
            wr_q      <= 1'b0;
            done_q    <= 1'b0;
            cpu_rst_q <= 1'b1;
        end else begin
            case (state_q)
                S_SYNC: begin
                    if (accept && in_data == SYNC_BYTE) begin
                        state_q <= S_ADDR_HI;
                    end
                end
                S_ADDR_HI: begin
                    if (accept) begin
                        addr_hi_q <= in_data;
                        state_q   <= S_ADDR_LO;
                    end
                end
                S_ADDR_LO: begin
                    if (accept) begin
                        // Address bits above SIZE are dropped.
                        ptr_q   <= SIZE'({addr_hi_q, in_data});
                        state_q <= S_CNT_HI;
                    end
                end
                S_CNT_HI: begin
                    if (accept) begin
                        cnt_q[15:8] <= in_data;
                        state_q     <= S_CNT_LO;
                    end
                end
                S_CNT_LO: begin
                    if (accept) begin
                        cnt_q[7:0] <= in_data;
                        if ({cnt_q[15:8], in_data} == 16'd0) begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            cpu_rst_q <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (word_valid) begin
                        state_q <= S_WRITE;
                        wr_q    <= 1'b1;
                    end
                end
                S_WRITE: begin
                    wr_q    <= 1'b0;
                    // Wraps silently past the top of RAM.
                    ptr_q   <= ptr_q + SIZE'(1);
                    words_q <= words_q + 16'd1;
                    if (words_q + 16'd1 == cnt_q) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        cpu_rst_q <= 1'b0;
                    end else begin
                        state_q <= S_DATA;
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_SYNC;
                end
            endcase
        end
    end

    // RAM port mux: loader until done, CPU afterwards, no added latency.
    always_comb begin
        ram_we   = wr_q;
        ram_addr = ptr_q;
        ram_data = packed_word;
        if (done_q) begin
            ram_we   = cpu_wrEn;
            ram_addr = cpu_addr;
            ram_data = cpu_data;
        end
    end

    assign cpu_rst       = cpu_rst_q;
    assign done          = done_q;
    assign words_written = words_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_vscpu_boot_loader.sv
// Self-checking bench for vscpu_boot_loader: a behavioural RAM, a write
// scoreboard fed from frame-level expectations, and one task per scenario.
module tb_vscpu_boot_loader;
    import vscpu_pkg::*;

    localparam int SIZE  = 14;
    localparam int DEPTH = 1 << SIZE;
    localparam int EW    = SIZE + 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic            in_valid = 1'b0;
    logic [7:0]      in_data  = 8'd0;
    logic            in_ready;
    logic            cpu_wrEn = 1'b0;
    logic [SIZE-1:0] cpu_addr = '0;
    logic [31:0]     cpu_data = 32'd0;
    logic            ram_we;
    logic [SIZE-1:0] ram_addr;
    logic [31:0]     ram_data;
    logic            cpu_rst;
    logic            done;
    logic [15:0]     words_written;
    state_t          dbg_state;

    vscpu_boot_loader #(.SIZE(SIZE), .SYNC_BYTE(8'hA5)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .cpu_wrEn      (cpu_wrEn),
        .cpu_addr      (cpu_addr),
        .cpu_data      (cpu_data),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_data      (ram_data),
        .cpu_rst       (cpu_rst),
        .done          (done),
        .words_written (words_written),
        .dbg_state     (dbg_state)
    );

    // Behavioural single-port RAM.
    logic [31:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks       = 0;
    int          failures     = 0;
    int          writes_seen  = 0;
    int          last_acc_cyc = -10;
    bit          iso_mode     = 1'b0;
    logic [EW-1:0] exp_q[$];
    logic [31:0]   frame_words[$];
    logic [EW-1:0] mon_e;

    // ---------------- scoreboard ----------------
    // Every loader write must match the next expected {addr,data} and must
    // land in the cycle right after the word's 4th byte was accepted.
    always @(negedge clk) begin
        if (rst && !done && ram_we) begin
            writes_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got addr=%h data=%h exp=none", ram_addr, ram_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({ram_addr, ram_data} !== mon_e) begin
                    failures++;
                    $display("FAIL write_content got addr=%h data=%h exp addr=%h data=%h",
                             ram_addr, ram_data, mon_e[EW-1:32], mon_e[31:0]);
                end
            end
            checks++;
            if (last_acc_cyc != cyc) begin
                failures++;
                $display("FAIL write_after_4th_byte got cyc=%0d exp=%0d", cyc, last_acc_cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst      = 1'b0;
        in_valid = 1'b0;
        cpu_wrEn = 1'b0;
        cpu_addr = '0;
        cpu_data = 32'd0;
        iso_mode = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        writes_seen = 0;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b, input int gap);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        if (iso_mode) begin
            cpu_addr = SIZE'($urandom_range(9000, 9999));
            cpu_data = $urandom;
        end
        for (int t = 0; t <= 40; t++) begin
            if (in_ready) begin
                last_acc_cyc = cyc + 1;
                @(negedge clk);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        checks++;
        failures++;
        $display("FAIL byte_accept_timeout got in_ready=%b exp=1 byte=%h", in_ready, b);
        in_valid = 1'b0;
    endtask

    function automatic int gap_for(input int mode, input bit is_data);
        if (mode == 1) return $urandom_range(0, 2);
        if (mode == 2 && is_data) return 2;
        return 0;
    endfunction

    // Sends a whole frame of frame_words (or only the first data_limit data
    // bytes). Expected writes are pushed from the frame-level rule:
    // word i lands at (start + i) mod 2^SIZE.
    task automatic send_frame(input logic [15:0] start, input logic [15:0] n,
                              input int mode, input int data_limit);
        logic [31:0] w;
        logic [7:0]  b;
        int          a;
        int          sent;
        for (int i = 0; i < int'(n); i++) begin
            a = (int'(start) + i) % DEPTH;
            exp_q.push_back({SIZE'(a), frame_words[i]});
        end
        send_byte(8'hA5, gap_for(mode, 1'b0));
        send_byte(start[15:8], gap_for(mode, 1'b0));
        send_byte(start[7:0], gap_for(mode, 1'b0));
        send_byte(n[15:8], gap_for(mode, 1'b0));
        send_byte(n[7:0], gap_for(mode, 1'b0));
        sent = 0;
        for (int i = 0; i < int'(n); i++) begin
            w = frame_words[i];
            for (int k = 0; k < 4; k++) begin
                if (sent >= data_limit) return;
                b = w[31 - 8*k -: 8];
                send_byte(b, gap_for(mode, 1'b1));
                sent++;
            end
        end
    endtask

    task automatic wait_done(input int budget);
        for (int t = 0; t < budget; t++) begin
            if (done) return;
            @(negedge clk);
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL done_timeout got done=%b exp=1", done);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL reset_cpu_rst got=%b exp=1", cpu_rst); end
        checks++; if (words_written !== 16'd0) begin failures++; $display("FAIL reset_words got=%0d exp=0", words_written); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        do_reset();
        frame_words.delete();
        frame_words.push_back(32'h20114045);
        frame_words.push_back(32'h10114001);
        send_frame(16'h0000, 16'd2, 0, 1000);
        // This cycle is the second write; handover is on the next edge.
        checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL basic_last_we got=%b exp=1", ram_we); end
        checks++; if (done !== 1'b0 || cpu_rst !== 1'b1) begin failures++; $display("FAIL basic_pre_done got done=%b cpu_rst=%b exp done=0 cpu_rst=1", done, cpu_rst); end
        @(negedge clk);
        checks++; if (done !== 1'b1 || cpu_rst !== 1'b0) begin failures++; $display("FAIL basic_handover got done=%b cpu_rst=%b exp done=1 cpu_rst=0", done, cpu_rst); end
        checks++; if (words_written !== 16'd2) begin failures++; $display("FAIL basic_words got=%0d exp=2", words_written); end
        checks++; if (mem[0] !== 32'h20114045) begin failures++; $display("FAIL basic_mem0 got=%h exp=20114045", mem[0]); end
        checks++; if (mem[1] !== 32'h10114001) begin failures++; $display("FAIL basic_mem1 got=%h exp=10114001", mem[1]); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_ready_done got=%b exp=0", in_ready); end
    endtask

    task automatic test_junk();
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'hFF, 1);
        send_byte(8'hA4, 0);
        @(negedge clk);
        checks++; if (writes_seen != 0 || words_written !== 16'd0 || done !== 1'b0) begin
            failures++; $display("FAIL junk_idle got writes=%0d words=%0d done=%b exp 0 0 0", writes_seen, words_written, done);
        end
        frame_words.delete();
        frame_words.push_back(32'h00000006);
        send_frame(16'h0064, 16'd1, 0, 1000);
        wait_done(20);
        checks++; if (mem[100] !== 32'h6) begin failures++; $display("FAIL junk_mem100 got=%h exp=00000006", mem[100]); end
        checks++; if (writes_seen != 1) begin failures++; $display("FAIL junk_writes got=%0d exp=1", writes_seen); end
    endtask

    task automatic test_wrap_gaps();
        logic [SIZE-1:0] top_a;
        logic [SIZE-1:0] zero_a;
        do_reset();
        frame_words.delete();
        frame_words.push_back($urandom);
        frame_words.push_back($urandom);
        send_frame(16'h3FFF, 16'd2, 2, 1000);
        wait_done(20);
        top_a  = '1;
        zero_a = '0;
        checks++; if (writes_seen != 2) begin failures++; $display("FAIL wrap_pulses got=%0d exp=2", writes_seen); end
        checks++; if (mem[top_a] !== frame_words[0]) begin failures++; $display("FAIL wrap_mem3fff got=%h exp=%h", mem[top_a], frame_words[0]); end
        checks++; if (mem[zero_a] !== frame_words[1]) begin failures++; $display("FAIL wrap_mem0 got=%h exp=%h", mem[zero_a], frame_words[1]); end
    endtask

    task automatic test_count_zero();
        do_reset();
        frame_words.delete();
        send_frame(16'h0010, 16'd0, 0, 1000);
        checks++; if (done !== 1'b1 || cpu_rst !== 1'b0) begin failures++; $display("FAIL zero_done got done=%b cpu_rst=%b exp 1 0", done, cpu_rst); end
        checks++; if (writes_seen != 0 || words_written !== 16'd0) begin failures++; $display("FAIL zero_nowrite got writes=%0d words=%0d exp 0 0", writes_seen, words_written); end
        cpu_wrEn = 1'b1;
        cpu_addr = SIZE'(50);
        cpu_data = 32'd7;
        #1;
        checks++; if (ram_we !== 1'b1 || ram_addr !== SIZE'(50) || ram_data !== 32'd7) begin
            failures++; $display("FAIL zero_mux got we=%b addr=%0d data=%0d exp 1 50 7", ram_we, ram_addr, ram_data);
        end
        @(negedge clk);
        cpu_wrEn = 1'b0;
        checks++; if (mem[50] !== 32'd7) begin failures++; $display("FAIL zero_cpu_write got=%h exp=7", mem[50]); end
    endtask

    task automatic test_reset_midload();
        logic [31:0]     first_w;
        logic [SIZE-1:0] a;
        do_reset();
        frame_words.delete();
        for (int i = 0; i < 3; i++) frame_words.push_back($urandom);
        first_w = frame_words[0];
        send_frame(16'h0200, 16'd3, 0, 4);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++; if (cpu_rst !== 1'b1 || done !== 1'b0 || ram_we !== 1'b0) begin
            failures++; $display("FAIL midrst_outputs got cpu_rst=%b done=%b we=%b exp 1 0 0", cpu_rst, done, ram_we);
        end
        checks++; if (words_written !== 16'd0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL midrst_state got words=%0d ready=%b exp 0 1", words_written, in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        frame_words.delete();
        for (int i = 0; i < 3; i++) frame_words.push_back($urandom);
        send_frame(16'h0400, 16'd3, 1, 1000);
        wait_done(30);
        checks++; if (words_written !== 16'd3) begin failures++; $display("FAIL midrst_words got=%0d exp=3", words_written); end
        a = SIZE'(16'h0200);
        checks++; if (mem[a] !== first_w) begin failures++; $display("FAIL midrst_kept got=%h exp=%h", mem[a], first_w); end
        for (int i = 0; i < 3; i++) begin
            a = SIZE'(16'h0400 + i);
            checks++; if (mem[a] !== frame_words[i]) begin failures++; $display("FAIL midrst_resent got=%h exp=%h idx=%0d", mem[a], frame_words[i], i); end
        end
    endtask

    task automatic test_isolation();
        logic [15:0]     start;
        logic [SIZE-1:0] a;
        do_reset();
        start = 16'($urandom_range(0, 8000));
        frame_words.delete();
        for (int i = 0; i < 3; i++) frame_words.push_back($urandom);
        iso_mode = 1'b1;
        cpu_wrEn = 1'b1;
        send_frame(start, 16'd3, 1, 1000);
        wait_done(30);
        checks++; if (ram_addr !== cpu_addr || ram_we !== 1'b1) begin
            failures++; $display("FAIL iso_mux_after_done got addr=%h we=%b exp addr=%h we=1", ram_addr, ram_we, cpu_addr);
        end
        cpu_wrEn = 1'b0;
        iso_mode = 1'b0;
        checks++; if (writes_seen != 3) begin failures++; $display("FAIL iso_writes got=%0d exp=3", writes_seen); end
        for (int i = 0; i < 3; i++) begin
            a = SIZE'(start + 16'(i));
            checks++; if (mem[a] !== frame_words[i]) begin failures++; $display("FAIL iso_mem got=%h exp=%h idx=%0d", mem[a], frame_words[i], i); end
        end
    endtask

    task automatic test_random_frames();
        logic [15:0]     start;
        logic [15:0]     n;
        logic [SIZE-1:0] a;
        for (int f = 0; f < 4; f++) begin
            do_reset();
            start = 16'($urandom_range(0, 65535));
            n     = 16'($urandom_range(1, 5));
            frame_words.delete();
            for (int i = 0; i < int'(n); i++) frame_words.push_back($urandom);
            send_frame(start, n, 1, 1000);
            wait_done(40);
            checks++; if (words_written !== n) begin failures++; $display("FAIL rand_words got=%0d exp=%0d", words_written, n); end
            for (int i = 0; i < int'(n); i++) begin
                a = SIZE'((int'(start) + i) % DEPTH);
                checks++; if (mem[a] !== frame_words[i]) begin failures++; $display("FAIL rand_mem got=%h exp=%h addr=%h", mem[a], frame_words[i], a); end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_frame();
        test_junk();
        test_wrap_gaps();
        test_count_zero();
        test_reset_midload();
        test_isolation();
        test_random_frames();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_writes got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
